// File: rtl/mmio_ctrl.sv
// mmio_ctrl -- memory-mapped I/O controller for the 0x8000_0000 region.
//
// Decodes CPU loads/stores on req_addr[7:0] and returns registered load data
// one cycle after the request, matching synchronous dmem/BIOS read latency.
// Owns the UART TX/RX handshakes and the cycle / retired-instruction counters.
//
// Register map (req_addr[7:0]):
//   0x00 R  status: bit0 = TX free, bit1 = RX available
//   0x04 R  RX data (zero-extended), pops one entry when available
//   0x08 W  TX data byte, accepted only while TX is free
//   0x10 R  cycle counter
//   0x14 R  retired-instruction counter
//   0x18 W  clear both counters (data ignored)
//
// Configuration macro: MMIO_RX_FIFO_EN
//   defined   -> RX buffer is an RX_FIFO_DEPTH-entry FIFO (power of two, >= 2)
//   undefined -> RX buffer is a single holding register; RX_FIFO_DEPTH unused
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_en, req_we             access strobe, 1 = store / 0 = load
//   req_addr, req_wdata        byte address, store data
//   rdata                      registered load data
//   inst_retire                one pulse per retired instruction
//   tx_data, tx_valid, tx_ready  UART transmit handshake
//   rx_data, rx_valid, rx_ready  UART receive handshake
module mmio_ctrl #(
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_en,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    typedef enum logic {
        TX_IDLE,
        TX_PEND
    } tx_state_t;

    tx_state_t   tx_state, tx_state_next;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] read_val;
    logic [7:0]  offset;
    logic        rd_req;
    logic        wr_req;
    logic        tx_pend;
    logic        tx_accept;
    logic        cnt_clear;
    logic        rx_empty;
    logic        rx_push;
    logic        rx_pop;
    logic [7:0]  rx_head;

    // Only the low address byte and low data byte are decoded.
    logic unused_bits;
    assign unused_bits = ^{req_addr[31:8], req_wdata[31:8], RX_FIFO_DEPTH};

    assign offset    = req_addr[7:0];
    assign rd_req    = req_en && !req_we;
    assign wr_req    = req_en && req_we;
    assign tx_pend   = (tx_state == TX_PEND);
    assign tx_valid  = tx_pend;
    assign tx_accept = wr_req && (offset == OFF_TXDATA) && !tx_pend;
    assign cnt_clear = wr_req && (offset == OFF_CLEAR);
    assign rx_push   = rx_valid && rx_ready;
    // A read of an empty buffer returns 0 and must not move any state.
    assign rx_pop    = rd_req && (offset == OFF_RXDATA) && !rx_empty;

    // ---------------------------------------------------------------- RX buffer
`ifdef MMIO_RX_FIFO_EN
    localparam int unsigned AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  fifo_mem [RX_FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        rx_full;

    // Extra MSB on each pointer distinguishes full (MSBs differ) from empty.
    assign rx_empty = (wr_ptr == rd_ptr);
    assign rx_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_ready = !rx_full;
    assign rx_head  = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rx_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (rx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) fifo_mem[wr_ptr[AW-1:0]] <= rx_data;
    end
`else
    logic [7:0] rx_hold;
    logic       rx_hold_valid;

    assign rx_empty = !rx_hold_valid;
    assign rx_ready = !rx_hold_valid;
    assign rx_head  = rx_hold;

    // Push wins over pop so a same-cycle pair leaves the new byte held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold       <= '0;
            rx_hold_valid <= 1'b0;
        end else if (rx_push) begin
            rx_hold       <= rx_data;
            rx_hold_valid <= 1'b1;
        end else if (rx_pop) begin
            rx_hold_valid <= 1'b0;
        end
    end
`endif

    // ---------------------------------------------------------------- TX path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_accept)            tx_state_next = TX_PEND;
            TX_PEND: if (tx_valid && tx_ready) tx_state_next = TX_IDLE;
            default:                           tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         tx_data <= '0;
        else if (tx_accept) tx_data <= req_wdata[7:0];
    end

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else if (cnt_clear) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
        end
    end

    // ---------------------------------------------------------------- load data
    // Read mux sees pre-edge state; the pop/clear land on the capturing edge.
    always_comb begin
        read_val = '0;
        case (offset)
            OFF_STATUS: read_val = {30'd0, !rx_empty, !tx_pend};
            OFF_RXDATA: read_val = rx_empty ? 32'd0 : {24'd0, rx_head};
            OFF_CYCLE:  read_val = cycle_cnt;
            OFF_INSTR:  read_val = inst_cnt;
            default:    read_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rdata <= '0;
        else if (rd_req) rdata <= read_val;
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
module tb_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_en = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] rdata;
    logic        inst_retire = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int tests = 0;
    int fails = 0;
    int sent_cnt = 0;
    logic [7:0] sent_byte = '0;

    mmio_ctrl #(.RX_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_en(req_en), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .inst_retire(inst_retire),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    // Record every byte that actually leaves on the TX handshake.
    always @(posedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            sent_cnt  <= sent_cnt + 1;
            sent_byte <= tx_data;
        end
    end

    task automatic do_read(input logic [7:0] off);
        req_en = 1'b1; req_we = 1'b0; req_addr = {24'h800000, off};
        @(negedge clk);
        req_en = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] off, input logic [31:0] data);
        req_en = 1'b1; req_we = 1'b1; req_addr = {24'h800000, off}; req_wdata = data;
        @(negedge clk);
        req_en = 1'b0; req_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want %h", rdata, 32'h0); end
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
        rst_n = 1'b1;
        do_read(8'h00);
        tests++; if (rdata !== 32'h1) begin fails++; $display("FAIL reset_status got %h want %h", rdata, 32'h1); end
        repeat (10) @(negedge clk);
        // One edge for the status read plus ten idle edges.
        do_read(8'h10);
        tests++; if (rdata !== 32'd11) begin fails++; $display("FAIL cycle_count got %0d want 11", rdata); end
    endtask

    task automatic test_tx;
        tx_ready = 1'b0;
        do_write(8'h08, 32'hFFFF_FF41);
        tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin fails++; $display("FAIL tx_start got valid=%b data=%h want 1/41", tx_valid, tx_data); end
        do_read(8'h00);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL tx_status_busy got %h want 0", rdata); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) do_write(8'h08, 32'h0000_0042);
            else        @(negedge clk);
            tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin fails++; $display("FAIL tx_hold[%0d] got valid=%b data=%h want 1/41", i, tx_valid, tx_data); end
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_done got valid=%b want 0", tx_valid); end
        tests++; if (sent_cnt !== 1 || sent_byte !== 8'h41) begin fails++; $display("FAIL tx_sent got cnt=%0d byte=%h want 1/41", sent_cnt, sent_byte); end
        do_read(8'h00);
        tests++; if (rdata !== 32'h1) begin fails++; $display("FAIL tx_status_free got %h want 1", rdata); end
    endtask

    task automatic test_rx;
`ifdef MMIO_RX_FIFO_EN
        logic [7:0] bytes [4];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL rx_ready_before[%0d] got %b want 1", i, rx_ready); end
            rx_valid = 1'b1; rx_data = bytes[i];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL rx_full_ready got %b want 0", rx_ready); end
        do_read(8'h00);
        tests++; if (rdata !== 32'h3) begin fails++; $display("FAIL rx_status_full got %h want 3", rdata); end
        for (int i = 0; i < 4; i++) begin
            do_read(8'h04);
            tests++; if (rdata !== {24'd0, bytes[i]}) begin fails++; $display("FAIL rx_pop[%0d] got %h want %h", i, rdata, bytes[i]); end
            if (i == 0) begin
                tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL rx_ready_after_pop got %b want 1", rx_ready); end
            end
        end
        do_read(8'h04);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rx_pop_empty got %h want 0", rdata); end
        do_read(8'h00);
        tests++; if (rdata !== 32'h1) begin fails++; $display("FAIL rx_status_empty got %h want 1", rdata); end
        // Push and pop together while non-empty keeps ordering.
        rx_valid = 1'b1; rx_data = 8'h55;
        @(negedge clk);
        rx_data = 8'h66;
        do_read(8'h04);
        rx_valid = 1'b0;
        tests++; if (rdata !== 32'h55) begin fails++; $display("FAIL rx_pushpop_first got %h want 55", rdata); end
        do_read(8'h04);
        tests++; if (rdata !== 32'h66) begin fails++; $display("FAIL rx_pushpop_second got %h want 66", rdata); end
        do_read(8'h04);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rx_pushpop_empty got %h want 0", rdata); end
`else
        rx_valid = 1'b1; rx_data = 8'h11;
        @(negedge clk);
        rx_valid = 1'b0;
        tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL rx_hold_ready got %b want 0", rx_ready); end
        do_read(8'h00);
        tests++; if (rdata !== 32'h3) begin fails++; $display("FAIL rx_status_full got %h want 3", rdata); end
        do_read(8'h04);
        tests++; if (rdata !== 32'h11) begin fails++; $display("FAIL rx_pop got %h want 11", rdata); end
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL rx_ready_after_pop got %b want 1", rx_ready); end
        do_read(8'h04);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rx_pop_empty got %h want 0", rdata); end
`endif
        // Pop on empty with a simultaneous push: returns 0, byte is kept.
        rx_valid = 1'b1; rx_data = 8'h77;
        do_read(8'h04);
        rx_valid = 1'b0;
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rx_empty_pushpop got %h want 0", rdata); end
        do_read(8'h04);
        tests++; if (rdata !== 32'h77) begin fails++; $display("FAIL rx_empty_pushpop_data got %h want 77", rdata); end
        do_read(8'h00);
        tests++; if (rdata !== 32'h1) begin fails++; $display("FAIL rx_status_final got %h want 1", rdata); end
    endtask

    task automatic test_counters;
        for (int i = 0; i < 7; i++) begin
            inst_retire = 1'b1;
            @(negedge clk);
            inst_retire = 1'b0;
            @(negedge clk);
        end
        do_read(8'h14);
        tests++; if (rdata !== 32'd7) begin fails++; $display("FAIL inst_count got %0d want 7", rdata); end
        inst_retire = 1'b1;
        do_write(8'h18, 32'hDEAD_BEEF);
        inst_retire = 1'b0;
        tests++; if (rdata !== 32'd7) begin fails++; $display("FAIL rdata_hold got %0d want 7", rdata); end
        do_read(8'h14);
        tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL inst_clear got %0d want 0", rdata); end
        do_read(8'h10);
        tests++; if (rdata !== 32'd1) begin fails++; $display("FAIL cycle_clear got %0d want 1", rdata); end
        do_read(8'h08);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL read_wo got %h want 0", rdata); end
        do_write(8'h14, 32'h0000_1234);
        do_read(8'h14);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL write_ro got %h want 0", rdata); end
        do_read(8'h20);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL read_unmapped got %h want 0", rdata); end
    endtask

    task automatic test_wrap;
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        do_read(8'h10);
        tests++; if (rdata !== 32'hFFFF_FFFE) begin fails++; $display("FAIL wrap_m2 got %h want fffffffe", rdata); end
        do_read(8'h10);
        tests++; if (rdata !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_m1 got %h want ffffffff", rdata); end
        do_read(8'h10);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL wrap_zero got %h want 0", rdata); end
    endtask

    task automatic test_reset_midop;
        tx_ready = 1'b0;
        do_write(8'h08, 32'h0000_005A);
        rx_valid = 1'b1; rx_data = 8'hA1;
        @(negedge clk);
`ifdef MMIO_RX_FIFO_EN
        rx_data = 8'hA2;
        @(negedge clk);
`endif
        rx_valid = 1'b0;
        tests++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL midop_pending got %b want 1", tx_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin fails++; $display("FAIL midop_tx_reset got valid=%b data=%h want 0/00", tx_valid, tx_data); end
        tests++; if (rx_ready !== 1'b1 || rdata !== 32'h0) begin fails++; $display("FAIL midop_rx_reset got ready=%b rdata=%h want 1/0", rx_ready, rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        do_read(8'h00);
        tests++; if (rdata !== 32'h1) begin fails++; $display("FAIL midop_status got %h want 1", rdata); end
        do_read(8'h04);
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL midop_rx_empty got %h want 0", rdata); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_counters();
        test_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
